inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port imem_req_valid  output  1  instruction-memory request valid.
REQ-005 SHALL have port imem_req_ready  input  1  memory accepts request this cycle.
REQ-006 SHALL have port imem_addr  output  32  request address, equal to current PC.
REQ-007 SHALL have port imem_rsp_valid  input  1  instruction word returned this cycle.
REQ-008 SHALL have port imem_rsp_data  input  32  returned instruction word.
REQ-009 SHALL have port redirect_valid  input  1  branch/jump redirect from downstream, one-cycle pulse.
REQ-010 SHALL have port redirect_pc  input  32  redirect target.
REQ-011 SHALL have port id_valid  output  1  decode-stage instruction valid.
REQ-012 SHALL have port id_ready  input  1  decode stage (ImmGen/control) consumes this cycle.
REQ-013 SHALL have port id_inst  output  32  instruction to decode; feeds the immediate generator inst input.
REQ-014 SHALL have port id_pc  output  32  PC of id_inst.

Function
REQ-015 SHALL keep a 32-bit PC register; imem_addr = PC.
REQ-016 SHALL use FSM states RUN, WAIT, DRAIN; at most one request outstanding.
REQ-017 In RUN, imem_req_valid SHALL be 1 iff redirect_valid=0 and (id_valid=0 or id_ready=1).
REQ-018 On request handshake (imem_req_valid and imem_req_ready) SHALL latch the request PC, set PC=PC+4 (mod 2^32 wrap), go WAIT.
REQ-019 In WAIT/DRAIN, imem_req_valid SHALL be 0.
REQ-020 In WAIT, on imem_rsp_valid without redirect: next cycle id_valid=1, id_inst=imem_rsp_data, id_pc=latched PC; go RUN (fetch-to-decode latency 1 cycle after response).
REQ-021 id_valid/id_inst/id_pc SHALL hold stable while id_valid=1 and id_ready=0.
REQ-022 id_valid SHALL clear on id_valid and id_ready unless refilled the same edge.
REQ-023 redirect_valid SHALL: set PC=redirect_pc, clear id_valid next cycle; has priority over every other event.
REQ-024 redirect in WAIT without response SHALL go DRAIN; in DRAIN stays DRAIN.
REQ-025 redirect in WAIT or DRAIN coinciding with imem_rsp_valid SHALL discard the response and go RUN.
REQ-026 In DRAIN, imem_rsp_valid SHALL be discarded (id_* unchanged) and FSM go RUN.
REQ-027 imem_rsp_valid in RUN SHALL be ignored.
REQ-028 Refill-while-full cannot occur; a request is issued only if the output buffer is empty or draining.

Reset
REQ-029 On rst_n=0, asynchronously: PC=RESET_PC, state=RUN, id_valid=0, id_inst=32'h0000_0013 (NOP), id_pc=0, latched PC=0.
REQ-030 Reset mid-WAIT SHALL abandon the outstanding request; any later response in RUN is ignored per REQ-027.
REQ-031 First request SHALL assert in the first cycle after rst_n deasserts, at RESET_PC.

Configuration
REQ-032 Macro FETCH_MISALIGN_TRAP_EN SHALL, when defined, add output id_misalign (1 bit, reset 0): redirect with redirect_pc[1:0]!=0 issues no request; instead next cycle id_valid=1, id_misalign=1, id_pc=redirect_pc, id_inst=NOP; all later fetches continue word-aligned after downstream redirect.
REQ-033 Without FETCH_MISALIGN_TRAP_EN, redirect_pc[1:0] SHALL be forced to 0 and no id_misalign port exists.

Structure
REQ-034 Shared package SHALL hold the FSM state encoding (RUN/WAIT/DRAIN), the NOP constant 32'h0000_0013, and the XLEN=32 constant.
REQ-035 One sub-module, fetch_buf (single-entry output register with valid/ready hold), SHALL be instantiated; the PC/FSM remain in inst_fetch.

Verification
REQ-036 Reset then imem_req_ready=1 always, response 1 cycle after each request, id_ready=1 -> imem_addr 0x0,0x4,0x8; id_inst/id_pc stream matches in order.
REQ-037 Response 0x00500093 at PC 0x0 with id_ready=0 for 3 cycles -> id_inst/id_pc hold 0x00500093/0x0; no new request until id_ready=1.
REQ-038 Redirect to 0x100 while WAIT, response arrives 2 cycles later -> response dropped, next request at 0x100, id_valid never shows stale word.
REQ-039 Redirect coincident with response -> response dropped, PC=redirect_pc, request issued next cycle.
REQ-040 PC=0xFFFF_FFFC fetched -> next imem_addr=0x0000_0000.
REQ-041 With FETCH_MISALIGN_TRAP_EN, redirect_pc=0x102 -> id_valid=1, id_misalign=1, id_pc=0x102, no imem request for that address.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | inst_fetch_pkg                                                     |
// | Shared constants, FSM encoding and PC helper for the fetch stage.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package inst_fetch_pkg;

  localparam int XLEN = 32;

  // Canonical RISC-V NOP (addi x0, x0, 0)
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN   = 2'd0,  // free to issue a request
    WAIT  = 2'd1,  // one request outstanding, response wanted
    DRAIN = 2'd2   // one request outstanding, response to be discarded
  } fetch_state_t;

  // Sequential next PC; wraps naturally at 2^32
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fetch_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_buf                                                          |
// | Single-entry decode output register with valid/ready hold.         |
// | Optional macro: FETCH_MISALIGN_TRAP_EN (adds misalign flag).       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module fetch_buf
  import inst_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            load,
  input  logic [XLEN-1:0] load_inst,
  input  logic [XLEN-1:0] load_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
  input  logic            load_misalign,
  output logic            misalign,
`endif
  input  logic            ready,
  output logic            valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc
);

  // Load wins over flush and consume so a same-edge refill is never lost;
  // otherwise the entry holds until consumed or flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      inst     <= NOP;
      pc       <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign <= 1'b0;
`endif
    end else if (load) begin
      valid    <= 1'b1;
      inst     <= load_inst;
      pc       <= load_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign <= load_misalign;
`endif
    end else if (flush || ready) begin
      valid    <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | inst_fetch                                                         |
// | PC register and single-outstanding fetch FSM feeding decode.       |
// | Optional macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect trap). |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        id_misalign
`endif
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;      // address of the outstanding request
  logic            req_valid;
  logic            req_fire;
  logic            req_block;   // fetch suspended after a misalign trap
  logic            buf_load;
  logic [XLEN-1:0] buf_inst;
  logic [XLEN-1:0] buf_pc;
  logic [XLEN-1:0] redir_target;

  // Fetches are always word aligned; the low bits only matter for the trap
  assign redir_target = {redirect_pc[XLEN-1:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_redirect;
  logic trap_hold;

  assign misalign_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign req_block         = trap_hold;

  // A misaligned redirect parks fetch until downstream redirects again
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      trap_hold <= 1'b0;
    else if (redirect_valid)
      trap_hold <= misalign_redirect;
  end
`else
  logic unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign req_block           = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= RUN;
    else
      state <= state_nxt;
  end

  // Next state, request valid and output-buffer load; redirect overrides all
  always_comb begin
    state_nxt = state;
    req_valid = 1'b0;
    buf_load  = 1'b0;
    buf_inst  = imem_rsp_data;
    buf_pc    = req_pc;
    case (state)
      RUN: begin
        // Request only when the output slot is empty or draining this edge
        req_valid = !redirect_valid && !req_block && (!id_valid || id_ready);
        if (req_valid && imem_req_ready)
          state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          state_nxt = RUN;
          buf_load  = !redirect_valid;
        end else if (redirect_valid) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_rsp_valid)
          state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
`ifdef FETCH_MISALIGN_TRAP_EN
    if (misalign_redirect) begin
      buf_load = 1'b1;
      buf_inst = NOP;
      buf_pc   = redirect_pc;
    end
`endif
  end

  assign imem_req_valid = req_valid;
  assign req_fire       = req_valid && imem_req_ready;
  assign imem_addr      = pc;

  // PC advance on accepted request, jump on redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      req_pc <= '0;
    end else if (redirect_valid) begin
      pc     <= redir_target;
    end else if (req_fire) begin
      req_pc <= pc;
      pc     <= pc_inc(pc);
    end
  end

  fetch_buf u_fetch_buf (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (redirect_valid),
    .load          (buf_load),
    .load_inst     (buf_inst),
    .load_pc       (buf_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
    .load_misalign (misalign_redirect),
    .misalign      (id_misalign),
`endif
    .ready         (id_ready),
    .valid         (id_valid),
    .inst          (id_inst),
    .pc            (id_pc)
  );

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_inst_fetch                                                      |
// | Randomized bench for inst_fetch against a transaction-level model. |
// | Optional macro: FETCH_MISALIGN_TRAP_EN (exercises the trap port).  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_inst_fetch;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        id_misalign;
`endif

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .id_misalign    (id_misalign)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // ---------------- memory responder ----------------
  bit          mem_busy = 0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = '0;
  int          fixed_lat = 0;   // <0 selects random latency 0..2 extra cycles
  bit          force_rsp = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        mis;
  } entry_t;

  entry_t      m_buf[$];   // what decode should currently see (0 or 1 entry)
  logic [31:0] m_pc;
  logic [31:0] m_req_pc;
  bit          m_out;      // a request is in flight
  bit          m_drop;     // the in-flight response must be thrown away
  bit          m_hold;     // fetch parked by a misalign trap

  function automatic void model_reset();
    m_buf.delete();
    m_pc = 32'h0; m_req_pc = 32'h0;
    m_out = 0; m_drop = 0; m_hold = 0;
  endfunction

  function automatic bit m_req_expected(input bit rv, input bit ir);
    return !m_out && !m_hold && !rv && (m_buf.size() == 0 || ir);
  endfunction

  function automatic void model_update(input bit rv, input logic [31:0] rpc, input bit rr,
                                       input bit ir, input bit rsp, input logic [31:0] rdata);
    bit fire;
    fire = m_req_expected(rv, ir) && rr;
    if (rv) begin
      m_buf.delete();
      if (m_out) begin
        if (rsp) begin m_out = 0; m_drop = 0; end
        else m_drop = 1;
      end
      m_hold = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (rpc[1:0] != 2'b00) begin
        m_buf.push_back('{inst: NOP_W, pc: rpc, mis: 1'b1});
        m_hold = 1;
      end
`endif
      m_pc = rpc & 32'hFFFF_FFFC;
    end else begin
      if (m_buf.size() != 0 && ir) void'(m_buf.pop_front());
      if (m_out && rsp) begin
        if (!m_drop) m_buf.push_back('{inst: rdata, pc: m_req_pc, mis: 1'b0});
        m_out = 0; m_drop = 0;
      end
      if (fire) begin
        m_req_pc = m_pc;
        m_pc     = m_pc + 32'd4;
        m_out    = 1;
      end
    end
  endfunction

  // One clock: drive at negedge, compare before the edge, advance model after it
  task automatic step(input bit rv, input logic [31:0] rpc, input bit rr, input bit ir);
    bit          rsp, hs;
    logic [31:0] rdata, hs_addr;
    @(negedge clk);
    rsp   = (mem_busy && mem_cnt == 0) || force_rsp;
    rdata = mem_busy ? mem_word(mem_addr) : 32'hDEAD_BEEF;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_req_ready = rr;
    id_ready       = ir;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rdata;
    #1;
    check("req_valid", 32'(imem_req_valid), 32'(m_req_expected(rv, ir)));
    check("imem_addr", imem_addr, m_pc);
    check("id_valid", 32'(id_valid), 32'(m_buf.size() != 0));
    if (m_buf.size() != 0) begin
      check("id_inst", id_inst, m_buf[0].inst);
      check("id_pc", id_pc, m_buf[0].pc);
`ifdef FETCH_MISALIGN_TRAP_EN
      check("id_misalign", 32'(id_misalign), 32'(m_buf[0].mis));
`endif
    end
    hs      = imem_req_valid && imem_req_ready;
    hs_addr = imem_addr;
    @(posedge clk);
    model_update(rv, rpc, rr, ir, rsp, rdata);
    if (mem_busy && mem_cnt == 0) mem_busy = 0;
    else if (mem_busy) mem_cnt--;
    if (hs) begin
      mem_busy = 1;
      mem_addr = hs_addr;
      mem_cnt  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 2));
    end
  endtask

  // Quiet inputs, hold reset, release on a falling edge
  task automatic apply_reset();
    redirect_valid = 0; imem_req_ready = 0; id_ready = 0;
    imem_rsp_valid = 0; force_rsp = 0;
    rst_n = 1'b0;
    #1;
    check("rst id_valid", 32'(id_valid), 32'h0);
    check("rst id_inst", id_inst, NOP_W);
    check("rst id_pc", id_pc, 32'h0);
    check("rst imem_addr", imem_addr, 32'h0);
    model_reset();
    mem_busy = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Let any outstanding fetch and buffered word retire without new requests
  task automatic settle();
    for (int i = 0; i < 10 && (m_out || m_buf.size() != 0); i++) step(0, 32'h0, 0, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    apply_reset();
    #1;
    check("first req_valid", 32'(imem_req_valid), 32'h1);
    check("first req addr", imem_addr, 32'h0);

    // Decode stall holds the first word and blocks further requests
    fixed_lat = 0;
    step(0, 32'h0, 1, 0);
    step(0, 32'h0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 32'h0, 1, 0);
      #1;
      check("hold id_inst", id_inst, 32'h0050_0093);
      check("hold id_pc", id_pc, 32'h0);
      check("hold no req", 32'(imem_req_valid), 32'h0);
    end

    // Back-to-back streaming
    for (int i = 0; i < 12; i++) step(0, 32'h0, 1, 1);

    // Redirect while waiting; response shows up later and must be dropped
    settle();
    fixed_lat = 2;
    step(0, 32'h0, 1, 1);
    step(1, 32'h100, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 32'h0, 1, 1);
      #1;
      check("drain id_valid", 32'(id_valid), 32'h0);
    end
    for (int i = 0; i < 4; i++) step(0, 32'h0, 1, 1);

    // Redirect coinciding with the response
    settle();
    fixed_lat = 0;
    step(0, 32'h0, 1, 1);
    step(1, 32'h200, 1, 1);
    #1;
    check("coinc addr", imem_addr, 32'h200);
    check("coinc id_valid", 32'(id_valid), 32'h0);
    for (int i = 0; i < 3; i++) step(0, 32'h0, 1, 1);

    // PC wrap at the top of the address space
    settle();
    step(1, 32'hFFFF_FFFC, 0, 1);
    step(0, 32'h0, 1, 1);
    #1;
    check("wrap addr", imem_addr, 32'h0);
    for (int i = 0; i < 3; i++) step(0, 32'h0, 1, 1);

    // Reset in the middle of a fetch, stray response afterwards
    fixed_lat = 2;
    for (int i = 0; i < 10 && !m_out; i++) step(0, 32'h0, 1, 1);
    @(negedge clk);
    apply_reset();
    force_rsp = 1;
    step(0, 32'h0, 0, 1);
    force_rsp = 0;
    for (int i = 0; i < 4; i++) step(0, 32'h0, 1, 1);

`ifdef FETCH_MISALIGN_TRAP_EN
    settle();
    step(1, 32'h102, 1, 1);
    #1;
    check("trap id_valid", 32'(id_valid), 32'h1);
    check("trap id_misalign", 32'(id_misalign), 32'h1);
    check("trap id_pc", id_pc, 32'h102);
    check("trap id_inst", id_inst, NOP_W);
    check("trap no req", 32'(imem_req_valid), 32'h0);
    for (int i = 0; i < 3; i++) step(0, 32'h0, 1, 1);
    step(1, 32'h300, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 32'h0, 1, 1);
`endif

    // Randomized traffic
    fixed_lat = -1;
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 10) == 0, $urandom, ($urandom % 4) != 0, ($urandom % 10) < 7);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
